// File: rtl/alu_multicycle_pkg.sv
// Shared ALU operation codes, FSM state encoding and small decode helpers.
package alu_multicycle_pkg;

    typedef enum logic [3:0] {
        ALU_PUR = 4'd0,
        ALU_AND = 4'd1,
        ALU_OR  = 4'd2,
        ALU_XOR = 4'd3,
        ALU_UNC = 4'd4,
        ALU_EQ  = 4'd5,
        ALU_ULT = 4'd6,
        ALU_SLT = 4'd7,
        ALU_ULE = 4'd8,
        ALU_SLE = 4'd9,
        ALU_UAD = 4'd10,
        ALU_SAD = 4'd11,
        ALU_UMT = 4'd12,
        ALU_SMT = 4'd13,
        ALU_SHL = 4'd14,
        ALU_SHR = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_MUL  = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_UMT) || (op == ALU_SMT);
    endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, WIDTH iterations.
module alu_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     partial;

    // acc = {high partial sum, remaining multiplier bits}; each step adds and shifts right
    assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign product = acc;

    // Load on start, then iterate until the last multiplier bit has been consumed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            mcand <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc   <= {{WIDTH{1'b0}}, multiplier};
                mcand <= multiplicand;
                count <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                acc   <= {partial, acc[WIDTH-1:1]};
                count <= count + CW'(1);
                if (count == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked WIDTH-bit ALU with iterative multiply, variable shifts and optional saturation.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BY_B = 0,
    parameter int SATURATE   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_high,
    output logic             shift_overflow,
    output logic             arithmetic_overflow
);
    localparam logic [WIDTH-1:0] S_MAX       = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES        = '1;
    localparam logic [WIDTH-1:0] SHAMT_LIMIT = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_e         state;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         op_q;
    logic               neg_q;
    logic               accept, mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_product, signed_product;
    logic [WIDTH:0]     sum_u;
    logic               sad_ovf;
    logic [WIDTH-1:0]   shamt;
    logic [WIDTH-1:0]   dp_result, mp_result, mp_high;
    logic               dp_sovf, dp_aovf, mp_aovf;

    assign in_ready  = (state == ALU_ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & is_mul_op(alu_op);
    assign sum_u     = {1'b0, a_q} + {1'b0, b_q};
    assign sad_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_u[WIDTH-1] != a_q[WIDTH-1]);
    assign shamt     = (SHIFT_BY_B != 0) ? b_q : ONE;

    // Multiplier starts from the raw inputs on the accept edge so the product is ready WIDTH edges later
    always_comb begin
        mul_a = operand_a;
        mul_b = operand_b;
        if (alu_op == ALU_SMT) begin
            if (operand_a[WIDTH-1]) mul_a = -operand_a;
            if (operand_b[WIDTH-1]) mul_b = -operand_b;
        end
    end

    alu_seq_multiplier #(.WIDTH(WIDTH)) u_mult (
        .clock        (clock),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (mul_a),
        .multiplier   (mul_b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Sign restoration, overflow and saturation for the multiply result
    always_comb begin
        signed_product = (op_q == ALU_SMT && neg_q) ? -mul_product : mul_product;
        mp_result      = signed_product[WIDTH-1:0];
        mp_high        = signed_product[2*WIDTH-1:WIDTH];
        if (op_q == ALU_SMT) mp_aovf = (mp_high != {WIDTH{mp_result[WIDTH-1]}});
        else                 mp_aovf = |mp_high;
        if (SATURATE != 0 && mp_aovf) begin
            if (op_q == ALU_SMT) mp_result = neg_q ? S_MIN : S_MAX;
            else                 mp_result = '1;
        end
    end

    // Single-cycle datapath over the latched operands
    always_comb begin
        dp_result = a_q;
        dp_sovf   = 1'b0;
        dp_aovf   = 1'b0;
        case (op_q)
            ALU_PUR: dp_result = a_q;
            ALU_AND: dp_result = a_q & b_q;
            ALU_OR:  dp_result = a_q | b_q;
            ALU_XOR: dp_result = a_q ^ b_q;
            ALU_UNC: dp_result = ONE;
            ALU_EQ:  dp_result = {{(WIDTH-1){1'b0}}, a_q == b_q};
            ALU_ULT: dp_result = {{(WIDTH-1){1'b0}}, a_q < b_q};
            ALU_SLT: dp_result = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_ULE: dp_result = {{(WIDTH-1){1'b0}}, a_q <= b_q};
            ALU_SLE: dp_result = {{(WIDTH-1){1'b0}}, $signed(a_q) <= $signed(b_q)};
            ALU_UAD: begin
                dp_aovf   = sum_u[WIDTH];
                dp_result = (SATURATE != 0 && sum_u[WIDTH]) ? ONES : sum_u[WIDTH-1:0];
            end
            ALU_SAD: begin
                dp_aovf   = sad_ovf;
                dp_result = (SATURATE != 0 && sad_ovf) ? (a_q[WIDTH-1] ? S_MIN : S_MAX)
                                                       : sum_u[WIDTH-1:0];
            end
            ALU_SHL, ALU_SHR: begin
                if (shamt == '0) begin
                    dp_result = a_q;
                end else if (shamt >= SHAMT_LIMIT) begin
                    dp_result = '0;
                    dp_sovf   = |a_q;
                end else if (op_q == ALU_SHL) begin
                    dp_result = a_q << shamt;
                    dp_sovf   = |(a_q & ~(ONES >> shamt));
                end else begin
                    dp_result = a_q >> shamt;
                    dp_sovf   = |(a_q & ~(ONES << shamt));
                end
            end
            default: dp_result = a_q;
        endcase
    end

    // Control FSM with registered result/flag outputs; DONE loads non-mul results one edge after entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= ALU_ST_IDLE;
            a_q                 <= '0;
            b_q                 <= '0;
            op_q                <= '0;
            neg_q               <= 1'b0;
            out_valid           <= 1'b0;
            result              <= '0;
            result_high         <= '0;
            shift_overflow      <= 1'b0;
            arithmetic_overflow <= 1'b0;
        end else begin
            case (state)
                ALU_ST_IDLE: begin
                    if (accept) begin
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        op_q  <= alu_op;
                        neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        state <= is_mul_op(alu_op) ? ALU_ST_MUL : ALU_ST_DONE;
                    end
                end
                ALU_ST_MUL: begin
                    if (mul_done && !mul_busy) begin
                        result              <= mp_result;
                        result_high         <= mp_high;
                        shift_overflow      <= 1'b0;
                        arithmetic_overflow <= mp_aovf;
                        out_valid           <= 1'b1;
                        state               <= ALU_ST_DONE;
                    end
                end
                ALU_ST_DONE: begin
                    if (!out_valid) begin
                        result              <= dp_result;
                        result_high         <= '0;
                        shift_overflow      <= dp_sovf;
                        arithmetic_overflow <= dp_aovf;
                        out_valid           <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ALU_ST_IDLE;
                    end
                end
                default: state <= ALU_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench: three configurations driven in lockstep, scoreboarded per instance.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        sov;
        logic        aov;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  res;
        logic [7:0]  hi;
        logic        sov;
        logic        aov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [3:0]  alu_op;
    logic [15:0] opa, opb;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [7:0]  r0, h0, r1, h1;
    logic [15:0] r2, h2;
    logic        so0, ao0, so1, ao1, so2, ao2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic seen0 = 1'b0, seen1 = 1'b0, seen2 = 1'b0;
    exp_t q0[$], q1[$], q2[$];
    vec_t tbl[27];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_multicycle #(.WIDTH(8), .SHIFT_BY_B(0), .SATURATE(0)) d0 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy0),
        .operand_a(opa[7:0]), .operand_b(opb[7:0]), .alu_op(alu_op),
        .out_valid(ov0), .out_ready(out_ready), .result(r0), .result_high(h0),
        .shift_overflow(so0), .arithmetic_overflow(ao0));

    alu_multicycle #(.WIDTH(8), .SHIFT_BY_B(1), .SATURATE(1)) d1 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy1),
        .operand_a(opa[7:0]), .operand_b(opb[7:0]), .alu_op(alu_op),
        .out_valid(ov1), .out_ready(out_ready), .result(r1), .result_high(h1),
        .shift_overflow(so1), .arithmetic_overflow(ao1));

    alu_multicycle #(.WIDTH(16), .SHIFT_BY_B(1), .SATURATE(0)) d2 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy2),
        .operand_a(opa), .operand_b(opb), .alu_op(alu_op),
        .out_valid(ov2), .out_ready(out_ready), .result(r2), .result_high(h2),
        .shift_overflow(so2), .arithmetic_overflow(ao2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model written with integer arithmetic on w-bit values
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a_in, input logic [15:0] b_in,
                                   input int w, input int shb, input int sat);
        exp_t   e;
        longint one, mask, a, b, sa, sb, p, k, maxp, minn;
        one  = 1;
        mask = (one << w) - 1;
        a    = longint'(a_in) & mask;
        b    = longint'(b_in) & mask;
        sa   = (a >= (one << (w - 1))) ? a - (one << w) : a;
        sb   = (b >= (one << (w - 1))) ? b - (one << w) : b;
        maxp = (one << (w - 1)) - 1;
        minn = -(one << (w - 1));
        e.res = '0; e.hi = '0; e.sov = 1'b0; e.aov = 1'b0; e.lat = 1;
        p = 0;
        case (op)
            ALU_PUR: p = a;
            ALU_AND: p = a & b;
            ALU_OR:  p = a | b;
            ALU_XOR: p = a ^ b;
            ALU_UNC: p = 1;
            ALU_EQ:  p = (a == b) ? 1 : 0;
            ALU_ULT: p = (a < b) ? 1 : 0;
            ALU_SLT: p = (sa < sb) ? 1 : 0;
            ALU_ULE: p = (a <= b) ? 1 : 0;
            ALU_SLE: p = (sa <= sb) ? 1 : 0;
            ALU_UAD: begin
                p = a + b;
                e.aov = (p > mask);
                if (sat != 0 && e.aov) p = mask;
            end
            ALU_SAD: begin
                p = sa + sb;
                e.aov = (p > maxp) || (p < minn);
                if (sat != 0 && e.aov) p = (p > 0) ? maxp : minn;
            end
            ALU_UMT, ALU_SMT: begin
                p = (op == ALU_UMT) ? a * b : sa * sb;
                e.lat = w + 1;
                e.hi  = 16'((p >>> w) & mask);
                e.aov = (op == ALU_UMT) ? (e.hi != 0) : ((p > maxp) || (p < minn));
                if (sat != 0 && e.aov) begin
                    if (op == ALU_UMT) p = mask;
                    else               p = (p > 0) ? maxp : minn;
                end
            end
            default: begin
                k = (shb != 0) ? b : 1;
                if (k == 0) begin
                    p = a;
                end else if (k >= w) begin
                    p = 0;
                    e.sov = (a != 0);
                end else if (op == ALU_SHL) begin
                    p = a << k;
                    e.sov = ((p >> w) != 0);
                end else begin
                    p = a >> k;
                    e.sov = ((a & ((one << k) - 1)) != 0);
                end
            end
        endcase
        e.res = 16'(p & mask);
        return e;
    endfunction

    task automatic score(input int id, input exp_t e, input logic [15:0] r, input logic [15:0] h,
                         input logic sv, input logic av);
        check($sformatf("d%0d_result", id), 32'(r), 32'(e.res));
        check($sformatf("d%0d_result_high", id), 32'(h), 32'(e.hi));
        check($sformatf("d%0d_shift_overflow", id), 32'(sv), 32'(e.sov));
        check($sformatf("d%0d_arith_overflow", id), 32'(av), 32'(e.aov));
        check($sformatf("d%0d_latency", id), 32'(cyc - accept_cyc), 32'(e.lat));
    endtask

    task automatic unexpected(input int id);
        checks++;
        failures++;
        $display("FAIL d%0d_unexpected_output actual=out_valid expected=no_pending_op", id);
    endtask

    // Monitors: score the first cycle of each result against the queued expectation
    always @(negedge clk) if (ov0 && !seen0) begin
        seen0 = 1'b1;
        if (q0.size() == 0) unexpected(0);
        else score(0, q0.pop_front(), {8'h00, r0}, {8'h00, h0}, so0, ao0);
    end
    always @(negedge clk) if (ov1 && !seen1) begin
        seen1 = 1'b1;
        if (q1.size() == 0) unexpected(1);
        else score(1, q1.pop_front(), {8'h00, r1}, {8'h00, h1}, so1, ao1);
    end
    always @(negedge clk) if (ov2 && !seen2) begin
        seen2 = 1'b1;
        if (q2.size() == 0) unexpected(2);
        else score(2, q2.pop_front(), r2, h2, so2, ao2);
    end

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input exp_t e0, input int hold);
        int n;
        n = 0;
        while (!(rdy0 && rdy1 && rdy2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(rdy0 && rdy1 && rdy2)) begin
            check("in_ready_timeout", 32'({rdy0, rdy1, rdy2}), 32'h7);
            return;
        end
        in_valid = 1'b1;
        alu_op   = op;
        opa      = a;
        opb      = b;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        q0.push_back(e0);
        q1.push_back(model(op, a, b, 8, 1, 1));
        q2.push_back(model(op, a, b, 16, 1, 0));
        in_valid = 1'b0;
        alu_op   = op ^ 4'h1;
        opa      = ~a;
        opb      = ~b;
        n = 0;
        while (!(seen0 && seen1 && seen2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(seen0 && seen1 && seen2))
            check("out_valid_timeout", 32'({seen0, seen1, seen2}), 32'h7);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(ov0), 32'h1);
            check("hold_in_ready", 32'(rdy0), 32'h0);
            check("hold_result", 32'(r0), 32'(e0.res));
            check("hold_arith_overflow", 32'(ao0), 32'(e0.aov));
            in_valid = (i == 2);
            alu_op   = ALU_SMT;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(rdy0), 32'h1);
        check("release_out_valid", 32'(ov0), 32'h0);
        out_ready = 1'b0;
        seen0 = 1'b0;
        seen1 = 1'b0;
        seen2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic saw;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'({rdy0, rdy1, rdy2}), 32'h7);
        check("reset_out_valid", 32'({ov0, ov1, ov2}), 32'h0);
        check("reset_result_d0", 32'({r0, h0}), 32'h0);
        check("reset_result_d2", 32'({r2, h2}), 32'h0);
        check("reset_flags", 32'({so0, ao0, so1, ao1, so2, ao2}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        //              op       a         b         res    hi     sov   aov   (W=8, shift by 1, wrap)
        tbl[0]  = '{ALU_UAD, 16'h00C8, 16'h0064, 8'h2C, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{ALU_SAD, 16'h0070, 16'h0020, 8'h90, 8'h00, 1'b0, 1'b1};
        tbl[2]  = '{ALU_SAD, 16'h00F0, 16'h0005, 8'hF5, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{ALU_SMT, 16'h00FD, 16'h0005, 8'hF1, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{ALU_SMT, 16'h0010, 16'h0010, 8'h00, 8'h01, 1'b0, 1'b1};
        tbl[5]  = '{ALU_UMT, 16'h000F, 16'h000F, 8'hE1, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{ALU_UMT, 16'hFFFF, 16'hFFFF, 8'h01, 8'hFE, 1'b0, 1'b1};
        tbl[7]  = '{ALU_SHL, 16'h0081, 16'h0004, 8'h02, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{ALU_SHR, 16'h00F0, 16'h0004, 8'h78, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{ALU_SHR, 16'h00F0, 16'h0005, 8'h78, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{ALU_SHR, 16'h00F0, 16'h0009, 8'h78, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{ALU_SHL, 16'h0001, 16'h0000, 8'h02, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{ALU_SLT, 16'h0080, 16'h0001, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{ALU_ULT, 16'h0080, 16'h0001, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[14] = '{ALU_AND, 16'h00F0, 16'h003C, 8'h30, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{ALU_OR,  16'h00F0, 16'h003C, 8'hFC, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{ALU_XOR, 16'h00F0, 16'h003C, 8'hCC, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{ALU_EQ,  16'h0055, 16'h0055, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{ALU_SLE, 16'h00FF, 16'h0000, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{ALU_UNC, 16'h1234, 16'h5678, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{ALU_PUR, 16'h00AB, 16'h0000, 8'hAB, 8'h00, 1'b0, 1'b0};
        tbl[21] = '{ALU_SMT, 16'h0080, 16'h0080, 8'h00, 8'h40, 1'b0, 1'b1};
        tbl[22] = '{ALU_SMT, 16'h0080, 16'h0001, 8'h80, 8'hFF, 1'b0, 1'b0};
        tbl[23] = '{ALU_SAD, 16'h0080, 16'h00FF, 8'h7F, 8'h00, 1'b0, 1'b1};
        tbl[24] = '{ALU_SHR, 16'h0001, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[25] = '{ALU_ULE, 16'h0001, 16'h0001, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[26] = '{ALU_EQ,  16'h0055, 16'h0054, 8'h00, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 27; i++) begin
            e.res = {8'h00, tbl[i].res};
            e.hi  = {8'h00, tbl[i].hi};
            e.sov = tbl[i].sov;
            e.aov = tbl[i].aov;
            e.lat = is_mul_op(tbl[i].op) ? 9 : 1;
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, e, 0);
        end

        // Back-pressure: result held for 5 cycles while a request pulse is dropped
        e.res = 16'h002C; e.hi = 16'h0000; e.sov = 1'b0; e.aov = 1'b1; e.lat = 1;
        run_op(ALU_UAD, 16'h00C8, 16'h0064, e, 5);

        // Reset three cycles into a multiply aborts it with no output
        in_valid = 1'b1; alu_op = ALU_UMT; opa = 16'h0012; opb = 16'h0034;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'({rdy0, rdy1, rdy2}), 32'h7);
        check("abort_out_valid", 32'({ov0, ov1, ov2}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        seen0 = 1'b0; seen1 = 1'b0; seen2 = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov0 | ov1 | ov2) saw = 1'b1;
        end
        check("abort_no_output_pulse", 32'(saw), 32'h0);
        e.res = 16'h00E1; e.hi = 16'h0000; e.sov = 1'b0; e.aov = 1'b0; e.lat = 9;
        run_op(ALU_UMT, 16'h000F, 16'h000F, e, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
